video_timing_gen: RTL and testbench

- Parametrised raster timing generator that produces pixel coordinates, sync, blanking and data-enable for the composite video encoders.
- Horizontal and vertical timings are fully parametrised: active, front porch, sync and back porch.
- Adds sync polarity, line/frame strobes and a runtime-selectable interlaced mode: alternating fields, extra line on the odd field, half-line vsync offset.
- Sits between the pixel clock enable source and the encoder/frame-buffer readout.

---
 rtl/video_timing_gen.sv | 103 ++++++++++
 tb/tb_video_timing_gen.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, blanking and strobe decodes.
// Interlaced mode adds a line to the odd field and shifts its vsync by half a line.
module video_timing_gen #(
    parameter int CW        = 10,
    parameter int H_ACTIVE  = 282,
    parameter int H_FP      = 0,
    parameter int H_SYNC    = 40,
    parameter int H_BP      = 19,
    parameter int V_ACTIVE  = 240,
    parameter int V_FP      = 5,
    parameter int V_SYNC    = 1,
    parameter int V_BP      = 15,
    parameter bit HSYNC_POL = 1'b1,
    parameter bit VSYNC_POL = 1'b1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clk_en,
    input  logic          interlace,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          field,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_HALF   = H_TOTAL / 2;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [CW-1:0] X_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] X_HALF     = CW'(H_HALF);
    localparam logic [CW-1:0] Y_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] Y_LAST_ODD = CW'(V_TOTAL);
    localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
    localparam logic [CW-1:0] HS_END_C   = CW'(HS_END);
    localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
    localparam logic [CW-1:0] VS_END_C   = CW'(VS_END);
    localparam logic [CW-1:0] H_ACTIVE_C = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACTIVE_C = CW'(V_ACTIVE);

    logic ilace_act;
    logic odd_long;
    logic x_last;
    logic y_last;
    logic hs_act;
    logic vs_full;
    logic vs_half;
    logic vs_act;

    // Only the odd field of an interlaced frame carries the extra line.
    assign odd_long = ilace_act & field;
    assign x_last   = (x == X_LAST);
    assign y_last   = (y == (odd_long ? Y_LAST_ODD : Y_LAST));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x         <= '0;
            y         <= '0;
            field     <= 1'b0;
            ilace_act <= 1'b0;
        end else if (clk_en) begin
            if (x_last) begin
                x <= '0;
                if (y_last) begin
                    y         <= '0;
                    ilace_act <= interlace;
                    field     <= interlace ? ~field : 1'b0;
                end else begin
                    y <= y + 1'b1;
                end
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign hs_act  = (x >= HS_START_C) && (x < HS_END_C);
    assign vs_full = (y >= VS_START_C) && (y < VS_END_C);
    // Odd-field vsync window runs from mid-line VS_START to mid-line VS_END.
    assign vs_half = ((y == VS_START_C) && (x >= X_HALF)) ||
                     ((y >  VS_START_C) && (y < VS_END_C)) ||
                     ((y == VS_END_C)   && (x < X_HALF));
    assign vs_act  = odd_long ? vs_half : vs_full;

    assign hsync       = hs_act ? HSYNC_POL : ~HSYNC_POL;
    assign vsync       = vs_act ? VSYNC_POL : ~VSYNC_POL;
    assign hblank      = (x >= H_ACTIVE_C);
    assign vblank      = (y >= V_ACTIVE_C);
    assign de          = ~hblank & ~vblank;
    assign line_start  = (x == '0);
    assign frame_start = (x == '0) && (y == '0);

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced 19x11 raster so whole frames stay short.
// A second instance with inverted sync polarity shares the stimulus.
module tb_video_timing_gen;

    localparam int CW = 8;
    // H: 10 active, 2 fp, 3 sync, 4 bp -> 19 total, half 9; V: 6 active, 2 fp, 1 sync, 2 bp -> 11 total
    localparam int HT = 19;

    logic clk = 1'b0;
    logic reset_n, clk_en, interlace;
    logic [CW-1:0] x, y, x_b, y_b;
    logic field, hsync, vsync, hblank, vblank, de, line_start, frame_start;
    logic field_b, hsync_b, vsync_b, hblank_b, vblank_b, de_b, line_start_b, frame_start_b;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CW(CW), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(2),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .interlace(interlace),
        .x(x), .y(y), .field(field), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .de(de),
        .line_start(line_start), .frame_start(frame_start)
    );

    video_timing_gen #(
        .CW(CW), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(4),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(1), .V_BP(2),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_neg (
        .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .interlace(interlace),
        .x(x_b), .y(y_b), .field(field_b), .hsync(hsync_b), .vsync(vsync_b),
        .hblank(hblank_b), .vblank(vblank_b), .de(de_b),
        .line_start(line_start_b), .frame_start(frame_start_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Walks one whole frame from (0,0), comparing every output against the raster position.
    task automatic scan_frame(input string tag, input int lines, input bit half_vs,
                              input bit exp_field, output int de_cnt,
                              output int vs_first, output int vs_last);
        int errs = 0;
        int first_bad = -1;
        de_cnt = 0;
        vs_first = -1;
        vs_last = -1;
        for (int n = 0; n < lines * HT; n++) begin
            int ex, ey;
            logic e_hs, e_vs, e_hb, e_vb, e_de, e_ls, e_fs;
            ex = n % HT;
            ey = n / HT;
            e_hs = (ex >= 12) && (ex < 15);
            e_vs = half_vs ? (((ey == 8) && (ex >= 9)) || ((ey == 9) && (ex < 9))) : (ey == 8);
            e_hb = (ex >= 10);
            e_vb = (ey >= 6);
            e_de = !e_hb && !e_vb;
            e_ls = (ex == 0);
            e_fs = (ex == 0) && (ey == 0);
            if (x !== CW'(ex) || y !== CW'(ey) || field !== exp_field ||
                hsync !== e_hs || vsync !== e_vs || hblank !== e_hb || vblank !== e_vb ||
                de !== e_de || line_start !== e_ls || frame_start !== e_fs ||
                hsync_b !== !e_hs || vsync_b !== !e_vs) begin
                errs++;
                if (first_bad < 0) first_bad = n;
            end
            if (de === 1'b1) de_cnt++;
            if (vsync === 1'b1) begin
                if (vs_first < 0) vs_first = n;
                vs_last = n;
            end
            step();
        end
        checks++;
        if (errs != 0)
            $display("FAIL %s_scan: %0d bad cycles (first at n=%0d), required 0", tag, errs, first_bad);
        else passes++;
        checks++;
        if (frame_start !== 1'b1 || x !== '0 || y !== '0)
            $display("FAIL %s_period: after %0d cycles x=%0d y=%0d frame_start=%b, required 0 0 1",
                     tag, lines * HT, x, y, frame_start);
        else passes++;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; clk_en = 1'b1; interlace = 1'b0;
        repeat (3) step();
        checks++; if (x !== '0) $display("FAIL reset_x: got %0d required 0", x); else passes++;
        checks++; if (y !== '0) $display("FAIL reset_y: got %0d required 0", y); else passes++;
        checks++; if (field !== 1'b0) $display("FAIL reset_field: got %b required 0", field); else passes++;
        checks++; if (de !== 1'b1) $display("FAIL reset_de: got %b required 1", de); else passes++;
        checks++; if (hblank !== 1'b0) $display("FAIL reset_hblank: got %b required 0", hblank); else passes++;
        checks++; if (vblank !== 1'b0) $display("FAIL reset_vblank: got %b required 0", vblank); else passes++;
        checks++; if (line_start !== 1'b1) $display("FAIL reset_line_start: got %b required 1", line_start); else passes++;
        checks++; if (frame_start !== 1'b1) $display("FAIL reset_frame_start: got %b required 1", frame_start); else passes++;
        checks++; if (hsync !== 1'b0) $display("FAIL reset_hsync: got %b required 0", hsync); else passes++;
        checks++; if (vsync !== 1'b0) $display("FAIL reset_vsync: got %b required 0", vsync); else passes++;
        checks++; if (hsync_b !== 1'b1) $display("FAIL reset_hsync_neg: got %b required 1", hsync_b); else passes++;
        checks++; if (vsync_b !== 1'b1) $display("FAIL reset_vsync_neg: got %b required 1", vsync_b); else passes++;
    endtask

    task automatic test_progressive();
        int dc, vf, vl;
        reset_n = 1'b1;
        scan_frame("prog", 11, 1'b0, 1'b0, dc, vf, vl);
        checks++; if (dc != 60) $display("FAIL prog_de_count: got %0d required 60", dc); else passes++;
        checks++;
        if (vf != 152 || vl != 170)
            $display("FAIL prog_vsync_window: got n=%0d..%0d required 152..170", vf, vl);
        else passes++;
    endtask

    task automatic test_clk_en();
        int fs_cnt = 0;
        int x_at_40 = -1;
        int changes = 0;
        for (int i = 0; i < 4 * 209; i++) begin
            clk_en = (i % 4 == 0);
            step();
            if (i == 39) x_at_40 = int'(x);
            if (frame_start === 1'b1) fs_cnt++;
        end
        checks++; if (x_at_40 != 10) $display("FAIL clken_x_rate: got x=%0d after 40 clocks required 10", x_at_40); else passes++;
        checks++; if (fs_cnt != 4) $display("FAIL clken_period: frame_start seen %0d samples required 4", fs_cnt); else passes++;
        clk_en = 1'b1;
        repeat (25) step();
        checks++;
        if (x !== 8'd6 || y !== 8'd1) $display("FAIL hold_pos: got x=%0d y=%0d required 6 1", x, y);
        else passes++;
        clk_en = 1'b0;
        repeat (1000) begin
            step();
            if (x !== 8'd6 || y !== 8'd1 || de !== 1'b1 || hsync !== 1'b0 || vsync !== 1'b0 ||
                line_start !== 1'b0 || frame_start !== 1'b0 || field !== 1'b0) changes++;
        end
        checks++; if (changes != 0) $display("FAIL hold_stable: %0d changed cycles required 0", changes); else passes++;
        clk_en = 1'b1;
        repeat (184) step();
        checks++; if (frame_start !== 1'b1) $display("FAIL hold_resume: frame_start=%b required 1", frame_start); else passes++;
    endtask

    task automatic test_interlace();
        int dc, vf, vl;
        reset_n = 1'b0; interlace = 1'b1;
        step(); step();
        reset_n = 1'b1;
        for (int f = 0; f < 4; f++) begin
            bit odd;
            odd = (f % 2 == 1);
            scan_frame(odd ? "ilace_f1" : "ilace_f0", odd ? 12 : 11, odd, odd, dc, vf, vl);
            checks++; if (dc != 60) $display("FAIL ilace_de_count: frame %0d got %0d required 60", f, dc); else passes++;
            checks++;
            if (odd && (vf != 161 || vl != 179))
                $display("FAIL ilace_vsync_half: frame %0d got n=%0d..%0d required 161..179", f, vf, vl);
            else if (!odd && (vf != 152 || vl != 170))
                $display("FAIL ilace_vsync_full: frame %0d got n=%0d..%0d required 152..170", f, vf, vl);
            else passes++;
        end
    endtask

    task automatic test_mode_change();
        int dc, vf, vl;
        interlace = 1'b0;
        scan_frame("drop_even", 11, 1'b0, 1'b0, dc, vf, vl);
        repeat (5 * HT) step();
        interlace = 1'b1;
        repeat (209 - 5 * HT - 1) step();
        checks++;
        if (x !== 8'd18 || y !== 8'd10 || field !== 1'b0 || frame_start !== 1'b0)
            $display("FAIL raise_midframe: got x=%0d y=%0d field=%b required 18 10 0", x, y, field);
        else passes++;
        step();
        checks++;
        if (frame_start !== 1'b1 || field !== 1'b1)
            $display("FAIL raise_wrap: frame_start=%b field=%b required 1 1", frame_start, field);
        else passes++;
        interlace = 1'b0;
        scan_frame("raise_odd", 12, 1'b1, 1'b1, dc, vf, vl);
        scan_frame("drop_prog", 11, 1'b0, 1'b0, dc, vf, vl);
    endtask

    task automatic test_async_reset();
        int dc, vf, vl;
        int n = 0;
        interlace = 1'b1;
        scan_frame("pre_rst", 11, 1'b0, 1'b0, dc, vf, vl);
        repeat (5 * HT + 7) step();
        checks++;
        if (x !== 8'd7 || y !== 8'd5 || field !== 1'b1)
            $display("FAIL rst_setup: got x=%0d y=%0d field=%b required 7 5 1", x, y, field);
        else passes++;
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (x !== '0) $display("FAIL arst_x: got %0d required 0", x); else passes++;
        checks++; if (y !== '0) $display("FAIL arst_y: got %0d required 0", y); else passes++;
        checks++; if (field !== 1'b0) $display("FAIL arst_field: got %b required 0", field); else passes++;
        checks++; if (de !== 1'b1) $display("FAIL arst_de: got %b required 1", de); else passes++;
        checks++; if (frame_start !== 1'b1) $display("FAIL arst_frame_start: got %b required 1", frame_start); else passes++;
        interlace = 1'b0;
        step(); step();
        reset_n = 1'b1;
        do begin
            step();
            n++;
        end while (frame_start !== 1'b1 && n < 400);
        checks++; if (n != 209) $display("FAIL arst_next_frame: got %0d cycles required 209", n); else passes++;
    endtask

    initial begin
        test_reset();
        test_progressive();
        test_clk_en();
        test_interlace();
        test_mode_change();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
